// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes driven to the ALU, alu_op encodings
// from decode, and the R-type funct values the ALU control understands.
package alu_pkg;

  // ALU control codes
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // alu_op encodings produced by the main decoder
  typedef enum logic [1:0] {
    ALU_OP_ADD   = 2'b00,
    ALU_OP_SUB   = 2'b01,
    ALU_OP_RTYPE = 2'b10,
    ALU_OP_SLT   = 2'b11
  } alu_op_e;

  // Supported R-type funct fields
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

endpackage

// File: rtl/alu_control_decode.sv
// Combinational ALU control decode: maps alu_op/funct to a 3-bit ALU control
// code and flags R-type instructions whose funct is not supported. Unsupported
// functs fall back to ADD so the ALU always sees a defined operation.
module alu_control_decode
  import alu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [2:0] control,
  output logic       illegal
);

  // Decode alu_op first, then funct for R-type
  always_comb begin
    control = ALU_ADD;
    illegal = 1'b0;
    case (alu_op_e'(alu_op))
      ALU_OP_ADD: control = ALU_ADD;
      ALU_OP_SUB: control = ALU_SUB;
      ALU_OP_SLT: control = ALU_SLT;
      ALU_OP_RTYPE: begin
        case (funct)
          FUNCT_ADD: control = ALU_ADD;
          FUNCT_SUB: control = ALU_SUB;
          FUNCT_AND: control = ALU_AND;
          FUNCT_OR:  control = ALU_OR;
          FUNCT_SLT: control = ALU_SLT;
          default: begin
            control = ALU_ADD;
            illegal = 1'b1;
          end
        endcase
      end
      default: control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register. Holds one decoded instruction, registers its ALU
// control code, and presents forwarded operands to the ALU.
// Optional feature macro: ID_EX_STALL_COUNT_EN adds a saturating 16-bit
// stall_count output (cycles with out_valid && !out_ready).
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. in_ready = !out_valid || out_ready, so a new entry may replace the held
// one in the same cycle it is consumed. While out_valid && !out_ready the held
// entry is frozen. flush drops the held entry and blocks capture that cycle
// without changing in_ready.
module id_ex_stage
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                in_alu_op,
  input  logic [5:0]                in_funct,
  input  logic [DATA_WIDTH-1:0]     in_rs_data,
  input  logic [DATA_WIDTH-1:0]     in_rt_data,
  input  logic [DATA_WIDTH-1:0]     in_imm,
  input  logic                      in_alu_src,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs_addr,
  input  logic [REG_ADDR_WIDTH-1:0] in_rt_addr,
  input  logic [REG_ADDR_WIDTH-1:0] in_rd_addr,
  input  logic                      in_reg_write,
  input  logic                      exmem_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
  input  logic [DATA_WIDTH-1:0]     exmem_result,
  input  logic                      memwb_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
  input  logic [DATA_WIDTH-1:0]     memwb_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     operand_a,
  output logic [DATA_WIDTH-1:0]     operand_b,
  output logic [2:0]                control_signal,
  output logic [REG_ADDR_WIDTH-1:0] out_rd_addr,
  output logic                      out_reg_write,
`ifdef ID_EX_STALL_COUNT_EN
  output logic [15:0]               stall_count,
`endif
  output logic                      illegal_funct
);

  logic                      valid_q;
  logic [2:0]                control_q;
  logic                      illegal_q;
  logic [DATA_WIDTH-1:0]     rs_data_q;
  logic [DATA_WIDTH-1:0]     rt_data_q;
  logic [DATA_WIDTH-1:0]     imm_q;
  logic                      alu_src_q;
  logic [REG_ADDR_WIDTH-1:0] rs_addr_q;
  logic [REG_ADDR_WIDTH-1:0] rt_addr_q;
  logic [REG_ADDR_WIDTH-1:0] rd_addr_q;
  logic                      reg_write_q;

  logic [2:0]                dec_control;
  logic                      dec_illegal;
  logic                      capture;
  logic [DATA_WIDTH-1:0]     fwd_a;
  logic [DATA_WIDTH-1:0]     fwd_b;

  alu_control_decode u_alu_control_decode (
    .alu_op  (in_alu_op),
    .funct   (in_funct),
    .control (dec_control),
    .illegal (dec_illegal)
  );

  assign in_ready = !valid_q || out_ready;
  assign capture  = in_valid && in_ready && !flush;

  // Pipeline register: reset, then flush, then capture, then drain on out_ready
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      control_q   <= ALU_ADD;
      illegal_q   <= 1'b0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      alu_src_q   <= 1'b0;
      rs_addr_q   <= '0;
      rt_addr_q   <= '0;
      rd_addr_q   <= '0;
      reg_write_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (capture) begin
      valid_q     <= 1'b1;
      control_q   <= dec_control;
      illegal_q   <= dec_illegal;
      rs_data_q   <= in_rs_data;
      rt_data_q   <= in_rt_data;
      imm_q       <= in_imm;
      alu_src_q   <= in_alu_src;
      rs_addr_q   <= in_rs_addr;
      rt_addr_q   <= in_rt_addr;
      rd_addr_q   <= in_rd_addr;
      reg_write_q <= in_reg_write;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  // Forwarding muxes: EX/MEM wins over MEM/WB; register 0 is never forwarded
  always_comb begin
    fwd_a = rs_data_q;
    if (exmem_reg_write && (exmem_rd == rs_addr_q) && (rs_addr_q != '0))
      fwd_a = exmem_result;
    else if (memwb_reg_write && (memwb_rd == rs_addr_q) && (rs_addr_q != '0))
      fwd_a = memwb_data;

    fwd_b = rt_data_q;
    if (exmem_reg_write && (exmem_rd == rt_addr_q) && (rt_addr_q != '0))
      fwd_b = exmem_result;
    else if (memwb_reg_write && (memwb_rd == rt_addr_q) && (rt_addr_q != '0))
      fwd_b = memwb_data;
  end

  assign out_valid      = valid_q;
  assign operand_a      = fwd_a;
  assign operand_b      = alu_src_q ? imm_q : fwd_b;
  assign control_signal = control_q;
  assign out_rd_addr    = rd_addr_q;
  assign out_reg_write  = reg_write_q && valid_q;
  assign illegal_funct  = illegal_q && valid_q;

`ifdef ID_EX_STALL_COUNT_EN
  logic [15:0] stall_cnt_q;

  // Count back-pressured cycles, saturating; only reset clears it
  always_ff @(posedge clk) begin
    if (!rst_n)
      stall_cnt_q <= '0;
    else if (valid_q && !out_ready && (stall_cnt_q != 16'hFFFF))
      stall_cnt_q <= stall_cnt_q + 16'd1;
  end

  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage. Inputs change 1 ns after the rising
// edge; outputs are sampled at that same point (or after a further #1 for
// purely combinational effects).
module tb_id_ex_stage;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_alu_op;
  logic [5:0]    in_funct;
  logic [DW-1:0] in_rs_data;
  logic [DW-1:0] in_rt_data;
  logic [DW-1:0] in_imm;
  logic          in_alu_src;
  logic [AW-1:0] in_rs_addr;
  logic [AW-1:0] in_rt_addr;
  logic [AW-1:0] in_rd_addr;
  logic          in_reg_write;
  logic          exmem_reg_write;
  logic [AW-1:0] exmem_rd;
  logic [DW-1:0] exmem_result;
  logic          memwb_reg_write;
  logic [AW-1:0] memwb_rd;
  logic [DW-1:0] memwb_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] operand_a;
  logic [DW-1:0] operand_b;
  logic [2:0]    control_signal;
  logic [AW-1:0] out_rd_addr;
  logic          out_reg_write;
  logic          illegal_funct;
`ifdef ID_EX_STALL_COUNT_EN
  logic [15:0]   stall_count;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  id_ex_stage #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_alu_op       (in_alu_op),
    .in_funct        (in_funct),
    .in_rs_data      (in_rs_data),
    .in_rt_data      (in_rt_data),
    .in_imm          (in_imm),
    .in_alu_src      (in_alu_src),
    .in_rs_addr      (in_rs_addr),
    .in_rt_addr      (in_rt_addr),
    .in_rd_addr      (in_rd_addr),
    .in_reg_write    (in_reg_write),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_data      (memwb_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .operand_a       (operand_a),
    .operand_b       (operand_b),
    .control_signal  (control_signal),
    .out_rd_addr     (out_rd_addr),
    .out_reg_write   (out_reg_write),
`ifdef ID_EX_STALL_COUNT_EN
    .stall_count     (stall_count),
`endif
    .illegal_funct   (illegal_funct)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driver tasks
  task automatic drive_instr(input logic [1:0] op, input logic [5:0] fn,
                             input logic [DW-1:0] rs_d, input logic [DW-1:0] rt_d,
                             input logic [DW-1:0] imm, input logic src,
                             input logic [AW-1:0] rs_a, input logic [AW-1:0] rt_a,
                             input logic [AW-1:0] rd, input logic rw);
    in_valid     = 1'b1;
    in_alu_op    = op;
    in_funct     = fn;
    in_rs_data   = rs_d;
    in_rt_data   = rt_d;
    in_imm       = imm;
    in_alu_src   = src;
    in_rs_addr   = rs_a;
    in_rt_addr   = rt_a;
    in_rd_addr   = rd;
    in_reg_write = rw;
  endtask

  task automatic clear_fwd();
    exmem_reg_write = 1'b0; exmem_rd = '0; exmem_result = '0;
    memwb_reg_write = 1'b0; memwb_rd = '0; memwb_data = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive_instr(2'b00, 6'd0, '0, '0, '0, 1'b0, '0, '0, '0, 1'b0);
    in_valid = 1'b0;
    clear_fwd();
    step(); step();
    rst_n = 1'b1;
    step();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_valid got=%0b want=0", out_valid); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got=%0b want=1", in_ready); else pass_cnt++;
    total_cnt++; if (control_signal !== 3'b010) $display("FAIL rst_control got=%b want=010", control_signal); else pass_cnt++;
    total_cnt++; if (operand_a !== 32'd0) $display("FAIL rst_operand_a got=%h want=0", operand_a); else pass_cnt++;
    total_cnt++; if (operand_b !== 32'd0) $display("FAIL rst_operand_b got=%h want=0", operand_b); else pass_cnt++;
    total_cnt++; if (illegal_funct !== 1'b0) $display("FAIL rst_illegal got=%0b want=0", illegal_funct); else pass_cnt++;
  endtask

  task automatic test_capture();
    out_ready = 1'b1;
    drive_instr(2'b10, 6'b100010, 32'd7, 32'd3, 32'd99, 1'b0, 5'd1, 5'd2, 5'd3, 1'b1);
    step();
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL cap_valid got=%0b want=1", out_valid); else pass_cnt++;
    total_cnt++; if (control_signal !== 3'b110) $display("FAIL cap_control got=%b want=110", control_signal); else pass_cnt++;
    total_cnt++; if (operand_a !== 32'd7) $display("FAIL cap_operand_a got=%h want=7", operand_a); else pass_cnt++;
    total_cnt++; if (operand_b !== 32'd3) $display("FAIL cap_operand_b got=%h want=3", operand_b); else pass_cnt++;
    total_cnt++; if (out_rd_addr !== 5'd3) $display("FAIL cap_rd got=%0d want=3", out_rd_addr); else pass_cnt++;
    total_cnt++; if (out_reg_write !== 1'b1) $display("FAIL cap_reg_write got=%0b want=1", out_reg_write); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp;
    out_ready = 1'b1;
    drive_instr(2'b00, 6'd0, 32'd20, 32'd5, 32'd0, 1'b0, 5'd1, 5'd2, 5'd4, 1'b1);
    exp_q.push_back({29'd20, 3'b010});
    step();
    exp = exp_q.pop_front();
    total_cnt++; if ({operand_a[28:0], control_signal} !== exp) $display("FAIL b2b_first got=%h want=%h", {operand_a[28:0], control_signal}, exp); else pass_cnt++;
    drive_instr(2'b11, 6'd0, 32'd21, 32'd5, 32'd0, 1'b0, 5'd1, 5'd2, 5'd4, 1'b1);
    exp_q.push_back({29'd21, 3'b111});
    step();
    exp = exp_q.pop_front();
    total_cnt++; if ({operand_a[28:0], control_signal} !== exp) $display("FAIL b2b_second got=%h want=%h", {operand_a[28:0], control_signal}, exp); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL b2b_valid got=%0b want=1", out_valid); else pass_cnt++;
  endtask

  task automatic test_stall();
    out_ready = 1'b1;
    drive_instr(2'b01, 6'd0, 32'h100, 32'h200, 32'd0, 1'b0, 5'd6, 5'd7, 5'd9, 1'b1);
    step();
    out_ready = 1'b0;
    drive_instr(2'b00, 6'd0, 32'h300, 32'h400, 32'd0, 1'b0, 5'd6, 5'd7, 5'd10, 1'b1);
    #1;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready got=%0b want=0", in_ready); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      step();
      total_cnt++; if (operand_a !== 32'h100) $display("FAIL stall_operand_a got=%h want=100", operand_a); else pass_cnt++;
      total_cnt++; if (control_signal !== 3'b110) $display("FAIL stall_control got=%b want=110", control_signal); else pass_cnt++;
      total_cnt++; if (out_rd_addr !== 5'd9) $display("FAIL stall_rd got=%0d want=9", out_rd_addr); else pass_cnt++;
      total_cnt++; if (out_valid !== 1'b1) $display("FAIL stall_valid got=%0b want=1", out_valid); else pass_cnt++;
    end
`ifdef ID_EX_STALL_COUNT_EN
    total_cnt++; if (stall_count !== 16'd3) $display("FAIL stall_count got=%0d want=3", stall_count); else pass_cnt++;
`endif
    out_ready = 1'b1;
    #1;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL unstall_in_ready got=%0b want=1", in_ready); else pass_cnt++;
    step();
    total_cnt++; if (operand_a !== 32'h300) $display("FAIL unstall_operand_a got=%h want=300", operand_a); else pass_cnt++;
    total_cnt++; if (control_signal !== 3'b010) $display("FAIL unstall_control got=%b want=010", control_signal); else pass_cnt++;
  endtask

  task automatic test_forwarding();
    out_ready = 1'b1;
    drive_instr(2'b00, 6'd0, 32'h11, 32'h22, 32'd0, 1'b0, 5'd5, 5'd5, 5'd8, 1'b1);
    exmem_reg_write = 1'b1; exmem_rd = 5'd5; exmem_result = 32'hAA;
    memwb_reg_write = 1'b1; memwb_rd = 5'd5; memwb_data = 32'hBB;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    total_cnt++; if (operand_a !== 32'hAA) $display("FAIL fwd_exmem_a got=%h want=aa", operand_a); else pass_cnt++;
    total_cnt++; if (operand_b !== 32'hAA) $display("FAIL fwd_exmem_b got=%h want=aa", operand_b); else pass_cnt++;
    exmem_reg_write = 1'b0;
    #1;
    total_cnt++; if (operand_a !== 32'hBB) $display("FAIL fwd_memwb_a got=%h want=bb", operand_a); else pass_cnt++;
    memwb_reg_write = 1'b0;
    #1;
    total_cnt++; if (operand_a !== 32'h11) $display("FAIL fwd_none_a got=%h want=11", operand_a); else pass_cnt++;
    memwb_reg_write = 1'b1;
    step();
    total_cnt++; if (operand_a !== 32'hBB) $display("FAIL fwd_stall_a got=%h want=bb", operand_a); else pass_cnt++;
    out_ready = 1'b1;
    drive_instr(2'b00, 6'd0, 32'h33, 32'h44, 32'd0, 1'b0, 5'd0, 5'd0, 5'd8, 1'b1);
    exmem_reg_write = 1'b1; exmem_rd = 5'd0;
    memwb_reg_write = 1'b1; memwb_rd = 5'd0;
    step();
    total_cnt++; if (operand_a !== 32'h33) $display("FAIL fwd_zero_a got=%h want=33", operand_a); else pass_cnt++;
    total_cnt++; if (operand_b !== 32'h44) $display("FAIL fwd_zero_b got=%h want=44", operand_b); else pass_cnt++;
    clear_fwd();
  endtask

  task automatic test_decode();
    logic [1:0] op_tab  [6] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};
    logic [5:0] fn_tab  [6] = '{6'b100000, 6'b100100, 6'b100101, 6'b101010, 6'b000000, 6'b000111};
    logic [2:0] ctl_tab [6] = '{3'b010, 3'b000, 3'b001, 3'b111, 3'b110, 3'b010};
    logic       ill_tab [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive_instr(op_tab[i], fn_tab[i], 32'd1, 32'd2, 32'hFFFFFFFC, 1'b1, 5'd1, 5'd2, 5'd3, 1'b1);
      step();
      total_cnt++; if (control_signal !== ctl_tab[i]) $display("FAIL dec_control[%0d] got=%b want=%b", i, control_signal, ctl_tab[i]); else pass_cnt++;
      total_cnt++; if (illegal_funct !== ill_tab[i]) $display("FAIL dec_illegal[%0d] got=%0b want=%0b", i, illegal_funct, ill_tab[i]); else pass_cnt++;
    end
    total_cnt++; if (operand_b !== 32'hFFFFFFFC) $display("FAIL imm_operand_b got=%h want=fffffffc", operand_b); else pass_cnt++;
    in_valid = 1'b0;
    step();
    total_cnt++; if (illegal_funct !== 1'b0) $display("FAIL illegal_gated got=%0b want=0", illegal_funct); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL drain_valid got=%0b want=0", out_valid); else pass_cnt++;
  endtask

  task automatic test_flush_and_reset();
    out_ready = 1'b1;
    drive_instr(2'b00, 6'd0, 32'h55, 32'h66, 32'd0, 1'b0, 5'd1, 5'd2, 5'd3, 1'b1);
    step();
    flush = 1'b1;
    drive_instr(2'b01, 6'd0, 32'h77, 32'h88, 32'd0, 1'b0, 5'd1, 5'd2, 5'd4, 1'b1);
    #1;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL flush_in_ready got=%0b want=1", in_ready); else pass_cnt++;
    step();
    flush = 1'b0; in_valid = 1'b0;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL flush_valid got=%0b want=0", out_valid); else pass_cnt++;
    total_cnt++; if (out_reg_write !== 1'b0) $display("FAIL flush_reg_write got=%0b want=0", out_reg_write); else pass_cnt++;
    drive_instr(2'b11, 6'd0, 32'h99, 32'h9A, 32'd0, 1'b0, 5'd1, 5'd2, 5'd5, 1'b1);
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    step();
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL prereset_valid got=%0b want=1", out_valid); else pass_cnt++;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL stall_reset_valid got=%0b want=0", out_valid); else pass_cnt++;
    total_cnt++; if (control_signal !== 3'b010) $display("FAIL stall_reset_control got=%b want=010", control_signal); else pass_cnt++;
    total_cnt++; if (operand_a !== 32'd0) $display("FAIL stall_reset_operand_a got=%h want=0", operand_a); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL stall_reset_in_ready got=%0b want=1", in_ready); else pass_cnt++;
`ifdef ID_EX_STALL_COUNT_EN
    total_cnt++; if (stall_count !== 16'd0) $display("FAIL stall_reset_count got=%0d want=0", stall_count); else pass_cnt++;
`endif
  endtask

  initial begin
    test_reset();
    test_capture();
    test_back_to_back();
    test_stall();
    test_forwarding();
    test_decode();
    test_flush_and_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
